gray_updn: RTL

GRAY_UPDN -- requirements
Module: gray_updn

---
 rtl/gray_pkg.sv | 15 +
 rtl/gray2bin.sv | 12 +
 rtl/gray_updn.sv | 60 ++++++
 3 files changed

// File: rtl/gray_pkg.sv
// gray_pkg: shared Gray-code constants and bin/Gray conversion helpers
// Functions work on 16-bit vectors (the widest legal counter); callers
// zero-extend their operand and cast the result back to their own width.
package gray_pkg;
  localparam int GRAY_DEFAULT_WIDTH = 3;
  function automatic logic [15:0] bin_to_gray(input logic [15:0] b);
    return b ^ (b >> 1);
  endfunction
  function automatic logic [15:0] gray_to_bin(input logic [15:0] g);
    logic [15:0] b;
    b[15] = g[15];
    for (int i = 14; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
endpackage

// File: rtl/gray2bin.sv
// gray2bin: combinational Gray-to-binary converter
// Ports: gray (in, WIDTH) Gray-coded value; bin (out, WIDTH) binary value.
module gray2bin
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);
  assign bin = WIDTH'(gray_to_bin(16'(gray)));
endmodule

// File: rtl/gray_updn.sv
// gray_updn: up/down Gray-code counter with load, clear and sticky wrap flags
// Ports: Clk, Reset_n (async active-low), En, Dir (1=up), Clr, Load,
//   Din (Gray load value) in; Output (registered Gray count), Overflow,
//   Underflow (sticky), Wrap (one-cycle pulse) out; Bin (binary count) out
//   only when GRAY_UPDN_BIN_OUT_EN is defined.
module gray_updn
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_DEFAULT_WIDTH,
  parameter int INIT  = 0
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             En,
  input  logic             Dir,
  input  logic             Clr,
  input  logic             Load,
  input  logic [WIDTH-1:0] Din,
  output logic [WIDTH-1:0] Output,
  output logic             Overflow,
  output logic             Underflow,
  output logic             Wrap
`ifdef GRAY_UPDN_BIN_OUT_EN
  ,
  output logic [WIDTH-1:0] Bin
`endif
);
  localparam logic [WIDTH-1:0] INIT_B = WIDTH'(INIT);
  localparam logic [WIDTH-1:0] INIT_G = WIDTH'(bin_to_gray(16'(INIT_B)));
  logic [WIDTH-1:0] b, nb, ld;
  logic up_wrap, dn_wrap, nwr, nov, nun;
  gray2bin #(.WIDTH(WIDTH)) u_g2b (.gray(Din), .bin(ld));
  // Clr and Load take priority over a step, so they also swallow any wrap.
  always_comb begin
    nb = Clr ? INIT_B : Load ? ld : En ? (Dir ? b + 1'b1 : b - 1'b1) : b;
    up_wrap = En & Dir & (&b);
    dn_wrap = En & ~Dir & ~(|b);
    nwr = ~Clr & ~Load & (up_wrap | dn_wrap);
    nov = ~Clr & (Overflow | (nwr & Dir));
    nun = ~Clr & (Underflow | (nwr & ~Dir));
  end
  // Output is registered from the next binary state so it never glitches.
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      b <= INIT_B;
      Output <= INIT_G;
      Overflow <= 1'b0;
      Underflow <= 1'b0;
      Wrap <= 1'b0;
    end else begin
      b <= nb;
      Output <= WIDTH'(bin_to_gray(16'(nb)));
      Overflow <= nov;
      Underflow <= nun;
      Wrap <= nwr;
    end
`ifdef GRAY_UPDN_BIN_OUT_EN
  assign Bin = b;
`endif
endmodule
